// File: rtl/adc_capture_pkg.sv
// -----------------------------------------------------------------------------
// adc_capture_pkg
// Shared definitions for the dual-channel ADC capture block:
//   - DATA_W_DEF : default ADC sample width per channel
//   - state_t    : acquisition / readout state machine encoding
//   - ob2tc      : offset-binary to two's complement conversion
// -----------------------------------------------------------------------------
package adc_capture_pkg;

    localparam int DATA_W_DEF = 14;

    typedef enum logic [2:0] {
        IDLE,
        PREFILL,
        WAIT_TRIG,
        CAPTURE,
        DONE,
        READ
    } state_t;

    // Offset-binary and two's complement differ only in the MSB, so the
    // conversion is an inversion of bit (width-1). The 32-bit container
    // keeps the function usable for any sample width up to 32.
    function automatic logic [31:0] ob2tc(input logic [31:0] raw, input int width);
        return raw ^ (32'd1 << (width - 1));
    endfunction

endpackage

// File: rtl/adc_capture_ram.sv
// -----------------------------------------------------------------------------
// adc_capture_ram
// Simple dual-port sample buffer: one write port, one read port with a
// registered (1-cycle) read. No reset on the storage or the read register so
// that it maps onto block RAM.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address (sampled every cycle)
//   rdata  out  mem[raddr] from the previous cycle
// -----------------------------------------------------------------------------
module adc_capture_ram #(
    parameter int WIDTH = 28,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [0:(1 << AW) - 1];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/adc_capture.sv
// -----------------------------------------------------------------------------
// adc_capture
// Registers two offset-binary ADC channels, converts them to two's complement,
// tracks sticky overrange and captures a triggered snapshot (with pre-trigger
// history) into a circular buffer that is then drained over rd_req/rd_valid.
// Ports:
//   clk, reset_n              sample clock, async active-low reset
//   adc_da/adc_db             raw offset-binary samples, channel A/B
//   adc_otr_a/adc_otr_b       ADC out-of-range flags
//   arm                       start (or restart) an acquisition
//   force_trig                trigger immediately (PREFILL/WAIT_TRIG only)
//   trig_level, trig_rising   signed level trigger on channel A
//   rd_req                    pop one sample pair (DONE/READ)
//   rd_valid, rd_data_a/b     read data, one cycle after an accepted rd_req
//   rd_last                   flags the final pair
//   busy, done                acquisition in progress / snapshot available
//   ovr_a, ovr_b              sticky overrange per channel
// -----------------------------------------------------------------------------
module adc_capture
    import adc_capture_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEPTH_LOG2 = 10,
    parameter int PRETRIG    = 128
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] adc_da,
    input  logic [DATA_W-1:0] adc_db,
    input  logic              adc_otr_a,
    input  logic              adc_otr_b,
    input  logic              arm,
    input  logic              force_trig,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_rising,
    input  logic              rd_req,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_last,
    output logic              busy,
    output logic              done,
    output logic              ovr_a,
    output logic              ovr_b
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0]      PRE_CNT  = CNT_W'(PRETRIG);
    localparam logic [CNT_W-1:0]      POST_CNT = CNT_W'(DEPTH - PRETRIG);
    localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PRE_OFS  = DEPTH_LOG2'(PRETRIG);
    // With no pre-trigger history there is nothing to prefill.
    localparam state_t ARM_STATE = (PRETRIG == 0) ? WAIT_TRIG : PREFILL;

    logic [DATA_W-1:0]     s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [1:0]            s1_otr_q, s1_otr_d;
    logic [DATA_W-1:0]     cur_a_q, cur_a_d, cur_b_q, cur_b_d;
    logic [DATA_W-1:0]     prev_a_q, prev_a_d;
    logic                  prev_valid_q, prev_valid_d;
    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] trig_ptr_q, trig_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  rd_last_q, rd_last_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [1:0]            ovr_q, ovr_d;

    logic                  ram_we;
    logic [2*DATA_W-1:0]   ram_rdata;
    logic                  level_hit;
    logic                  trig_fire;
    logic                  rd_accept;
    logic [1:0]            otr_pins;

    assign otr_pins = {adc_otr_b, adc_otr_a};

    // Per-channel overrange: stage-1 register plus sticky flag. arm wins over
    // a simultaneous overrange so a fresh acquisition always starts clean.
    for (genvar gi = 0; gi < 2; gi++) begin : g_ovr
        assign s1_otr_d[gi] = otr_pins[gi];
        assign ovr_d[gi]    = arm ? 1'b0
                            : (ovr_q[gi] | (s1_otr_q[gi] & (state_q != IDLE)));
    end

    always_comb begin
        s1_a_d       = adc_da;
        s1_b_d       = adc_db;
        cur_a_d      = DATA_W'(ob2tc(32'(s1_a_q), DATA_W));
        cur_b_d      = DATA_W'(ob2tc(32'(s1_b_q), DATA_W));
        prev_a_d     = cur_a_q;
        // prev becomes meaningful once one post-arm sample has passed through.
        prev_valid_d = prev_valid_q | (state_q != IDLE);

        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        trig_ptr_d = trig_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        ram_we     = 1'b0;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;

        level_hit = 1'b0;
        if (prev_valid_q) begin
            if (trig_rising) begin
                level_hit = ($signed(prev_a_q) <  $signed(trig_level)) &&
                            ($signed(cur_a_q)  >= $signed(trig_level));
            end else begin
                level_hit = ($signed(prev_a_q) >  $signed(trig_level)) &&
                            ($signed(cur_a_q)  <= $signed(trig_level));
            end
        end

        // Level triggers only count once the history is full; force_trig
        // bypasses that. Both at once are a single trigger.
        trig_fire = (force_trig && (state_q == PREFILL || state_q == WAIT_TRIG)) ||
                    (level_hit && state_q == WAIT_TRIG);
        rd_accept = rd_req && (state_q == DONE || state_q == READ) && (cnt_q != FULL_CNT);

        case (state_q)
            PREFILL, WAIT_TRIG, CAPTURE: begin
                ram_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (trig_fire) begin
                    // The trigger sample is written this cycle and counts as
                    // the first post-trigger sample.
                    trig_ptr_d = wr_ptr_q;
                    cnt_d      = CNT_W'(1);
                    if (POST_CNT == CNT_W'(1)) begin
                        state_d  = DONE;
                        rd_ptr_d = wr_ptr_q - PRE_OFS;
                        cnt_d    = '0;
                    end else begin
                        state_d = CAPTURE;
                    end
                end else if (state_q == PREFILL && (cnt_q + 1'b1) == PRE_CNT) begin
                    state_d = WAIT_TRIG;
                end else if (state_q == CAPTURE && (cnt_q + 1'b1) == POST_CNT) begin
                    state_d  = DONE;
                    rd_ptr_d = trig_ptr_q - PRE_OFS;
                    cnt_d    = '0;
                end
            end
            DONE, READ: begin
                // cnt counts pairs handed out during readout.
                if (rd_accept) begin
                    rd_valid_d = 1'b1;
                    rd_last_d  = (cnt_q == LAST_CNT);
                    rd_ptr_d   = rd_ptr_q + 1'b1;
                    cnt_d      = cnt_q + 1'b1;
                    state_d    = READ;
                end else if (state_q == READ && rd_last_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
            end
        endcase

        if (arm) begin
            state_d      = ARM_STATE;
            wr_ptr_d     = '0;
            cnt_d        = '0;
            prev_valid_d = 1'b0;
            ram_we       = 1'b0;
            rd_valid_d   = 1'b0;
            rd_last_d    = 1'b0;
        end

        busy_d = (state_d == PREFILL) || (state_d == WAIT_TRIG) || (state_d == CAPTURE);
        done_d = (state_d == DONE) || (state_d == READ);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_otr_q     <= '0;
            cur_a_q      <= '0;
            cur_b_q      <= '0;
            prev_a_q     <= '0;
            prev_valid_q <= 1'b0;
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            trig_ptr_q   <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            rd_valid_q   <= 1'b0;
            rd_last_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ovr_q        <= '0;
        end else begin
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_otr_q     <= s1_otr_d;
            cur_a_q      <= cur_a_d;
            cur_b_q      <= cur_b_d;
            prev_a_q     <= prev_a_d;
            prev_valid_q <= prev_valid_d;
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            trig_ptr_q   <= trig_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            rd_valid_q   <= rd_valid_d;
            rd_last_q    <= rd_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ovr_q        <= ovr_d;
        end
    end

    // The RAM read register is free-running on rd_ptr; the pair it returns is
    // the one addressed when the request was accepted.
    adc_capture_ram #(
        .WIDTH (2 * DATA_W),
        .AW    (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata ({cur_a_q, cur_b_q}),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    // Gate with rd_valid so the unreset RAM register never shows on the pins.
    assign rd_data_a = rd_valid_q ? ram_rdata[2*DATA_W-1:DATA_W] : '0;
    assign rd_data_b = rd_valid_q ? ram_rdata[DATA_W-1:0]        : '0;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ovr_a     = ovr_q[0];
    assign ovr_b     = ovr_q[1];

endmodule

// File: tb/tb_adc_capture.sv
module tb_adc_capture;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [13:0] adc_da, adc_db, trig_level;
    logic        adc_otr_a, adc_otr_b, arm, force_trig, trig_rising, rd_req;
    logic        rd_valid, rd_last, busy, done, ovr_a, ovr_b;
    logic [13:0] rd_data_a, rd_data_b;

    logic        arm0, force0, rd_req0;
    logic        rd_valid0, rd_last0, busy0, done0, ovr_a0, ovr_b0;
    logic [13:0] rd_data_a0, rd_data_b0;

    int checks   = 0;
    int failures = 0;

    logic [13:0] got_a [0:1023];
    logic [13:0] got_b [0:1023];
    int n_valid, n_last, last_pos, gaps;

    always #5 clk = ~clk;

    adc_capture u_dut (
        .clk(clk), .reset_n(reset_n), .adc_da(adc_da), .adc_db(adc_db),
        .adc_otr_a(adc_otr_a), .adc_otr_b(adc_otr_b), .arm(arm),
        .force_trig(force_trig), .trig_level(trig_level), .trig_rising(trig_rising),
        .rd_req(rd_req), .rd_valid(rd_valid), .rd_data_a(rd_data_a),
        .rd_data_b(rd_data_b), .rd_last(rd_last), .busy(busy), .done(done),
        .ovr_a(ovr_a), .ovr_b(ovr_b)
    );

    // Small instance: no pre-trigger history, 8-deep buffer.
    adc_capture #(.DATA_W(14), .DEPTH_LOG2(3), .PRETRIG(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .adc_da(adc_da), .adc_db(adc_db),
        .adc_otr_a(adc_otr_a), .adc_otr_b(adc_otr_b), .arm(arm0),
        .force_trig(force0), .trig_level(trig_level), .trig_rising(trig_rising),
        .rd_req(rd_req0), .rd_valid(rd_valid0), .rd_data_a(rd_data_a0),
        .rd_data_b(rd_data_b0), .rd_last(rd_last0), .busy(busy0), .done(done0),
        .ovr_a(ovr_a0), .ovr_b(ovr_b0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Raw offset-binary code for a signed sample value.
    function automatic logic [13:0] enc(input int v);
        return 14'(v + 8192);
    endfunction

    // Expected two's complement read-back value.
    function automatic logic [13:0] tc(input int v);
        return 14'(v);
    endfunction

    task automatic wait_done(input int budget, input string tag);
        gaps = 0;
        for (int i = 0; i < budget; i++) begin
            if (done) break;
            tick();
            if (!done && !busy) gaps++;
        end
        chk(tag, {31'd0, done}, 32'd1);
        chk({tag, "_busy_gap"}, gaps, 0);
    endtask

    task automatic read_all(input int n);
        n_valid  = 0;
        n_last   = 0;
        last_pos = -1;
        rd_req   = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            if (rd_valid) begin
                if (n_valid < 1024) begin
                    got_a[n_valid] = rd_data_a;
                    got_b[n_valid] = rd_data_b;
                end
                if (rd_last) begin
                    n_last++;
                    last_pos = n_valid;
                end
                n_valid++;
            end
        end
        rd_req = 1'b0;
        tick();
    endtask

    // Assumes the DUT is already armed: hold -100 long enough to finish the
    // prefill, then ramp -99..+100 one step per cycle and hold +100.
    task automatic drive_ramp();
        adc_da = enc(-100);
        repeat (200) tick();
        for (int v = -99; v <= 100; v++) begin
            adc_da = enc(v);
            tick();
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        adc_da      = enc(0);
        adc_db      = enc(0);
        adc_otr_a   = 1'b0;
        adc_otr_b   = 1'b0;
        arm         = 1'b0;
        force_trig  = 1'b0;
        trig_level  = 14'h1FFF;
        trig_rising = 1'b1;
        rd_req      = 1'b0;
        arm0        = 1'b0;
        force0      = 1'b0;
        rd_req0     = 1'b0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_rd_last", {31'd0, rd_last}, 32'd0);
        chk("rst_ovr", {30'd0, ovr_b, ovr_a}, 32'd0);
        chk("rst_rd_data", {18'd0, rd_data_a}, 32'd0);
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (2) tick();

        // ---- conversion on the PRETRIG=0 instance ----
        adc_da = 14'h0000;
        adc_db = 14'h2000;
        repeat (3) tick();
        arm0 = 1'b1;
        tick();
        arm0 = 1'b0;
        adc_da = 14'h2000;
        chk("conv_busy", {31'd0, busy0}, 32'd1);
        tick();
        adc_da = 14'h3FFF;
        force0 = 1'b1;
        tick();
        force0 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done0) break;
            tick();
        end
        chk("conv_done", {31'd0, done0}, 32'd1);
        rd_req0 = 1'b1;
        n_valid = 0;
        n_last  = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rd_valid0) begin
                if (n_valid == 0) chk("conv_0000", {18'd0, rd_data_a0}, {18'd0, 14'h2000});
                if (n_valid == 1) chk("conv_2000", {18'd0, rd_data_a0}, 32'd0);
                if (n_valid == 2) chk("conv_3fff", {18'd0, rd_data_a0}, {18'd0, 14'h1FFF});
                if (n_valid == 7) chk("conv_last", {31'd0, rd_last0}, 32'd1);
                if (n_valid == 0) chk("conv_b", {18'd0, rd_data_b0}, 32'd0);
                if (rd_last0) n_last++;
                n_valid++;
            end
        end
        rd_req0 = 1'b0;
        tick();
        chk("conv_count", n_valid, 8);
        chk("conv_nlast", n_last, 1);
        chk("conv_idle", {29'd0, done0, busy0, rd_valid0}, 32'd0);
        chk("conv_ovr", {30'd0, ovr_b0, ovr_a0}, 32'd0);
        $display("step conversion: pairs=%0d last_flags=%0d", n_valid, n_last);

        // ---- IDLE ignores overrange and force_trig ----
        adc_otr_a  = 1'b1;
        force_trig = 1'b1;
        tick();
        force_trig = 1'b0;
        tick();
        adc_otr_a = 1'b0;
        repeat (2) tick();
        chk("idle_ovr_a", {31'd0, ovr_a}, 32'd0);
        chk("idle_force", {31'd0, busy}, 32'd0);
        $display("step idle: ovr_a=%0d busy=%0d", ovr_a, busy);

        // ---- rising trigger ----
        trig_level  = 14'h0000;
        trig_rising = 1'b1;
        adc_db      = enc(5);
        adc_da      = enc(-100);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("rise_busy", {31'd0, busy}, 32'd1);
        chk("rise_done0", {31'd0, done}, 32'd0);
        drive_ramp();
        wait_done(2000, "rise_done");
        read_all(1030);
        chk("rise_count", n_valid, 1024);
        chk("rise_nlast", n_last, 1);
        chk("rise_lastpos", last_pos, 1023);
        chk("rise_a0", {18'd0, got_a[0]}, {18'd0, tc(-100)});
        chk("rise_a127", {18'd0, got_a[127]}, {18'd0, tc(-1)});
        chk("rise_a128", {18'd0, got_a[128]}, {18'd0, tc(0)});
        chk("rise_a129", {18'd0, got_a[129]}, {18'd0, tc(1)});
        chk("rise_a1023", {18'd0, got_a[1023]}, {18'd0, tc(100)});
        chk("rise_b128", {18'd0, got_b[128]}, {18'd0, tc(5)});
        chk("rise_idle", {30'd0, done, rd_valid}, 32'd0);
        $display("step rising: pairs=%0d last_at=%0d a127=%h a128=%h",
                 n_valid, last_pos, got_a[127], got_a[128]);

        // ---- falling trigger, crossing during prefill ignored, overrange ----
        trig_rising = 1'b0;
        adc_da      = enc(50);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        repeat (20) tick();
        adc_da = enc(-30);
        repeat (40) tick();
        adc_da = enc(50);
        repeat (200) tick();
        chk("fall_prefill_busy", {31'd0, busy}, 32'd1);
        adc_da = enc(-70);
        repeat (10) tick();
        chk("fall_ovr_b_pre", {31'd0, ovr_b}, 32'd0);
        adc_otr_b = 1'b1;
        tick();
        adc_otr_b = 1'b0;
        tick();
        chk("fall_ovr_b", {31'd0, ovr_b}, 32'd1);
        chk("fall_ovr_a", {31'd0, ovr_a}, 32'd0);
        wait_done(2000, "fall_done");
        read_all(1030);
        chk("fall_count", n_valid, 1024);
        chk("fall_a127", {18'd0, got_a[127]}, {18'd0, tc(50)});
        chk("fall_a128", {18'd0, got_a[128]}, {18'd0, tc(-70)});
        chk("fall_ovr_b_held", {31'd0, ovr_b}, 32'd1);
        chk("fall_ovr_a_held", {31'd0, ovr_a}, 32'd0);
        $display("step falling: pairs=%0d a127=%h a128=%h ovr_b=%0d",
                 n_valid, got_a[127], got_a[128], ovr_b);

        // ---- abort during readout, then a full new capture ----
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("abort_ovr_b_clr", {31'd0, ovr_b}, 32'd0);
        repeat (5) tick();
        force_trig = 1'b1;
        tick();
        force_trig = 1'b0;
        wait_done(2000, "abort_done");
        rd_req  = 1'b1;
        n_valid = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rd_valid) n_valid++;
        end
        chk("abort_pops", n_valid, 10);
        adc_da = enc(-100);
        arm    = 1'b1;
        tick();
        arm    = 1'b0;
        rd_req = 1'b0;
        chk("abort_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd1);
        trig_rising = 1'b1;
        drive_ramp();
        wait_done(2000, "recap_done");
        read_all(1030);
        chk("recap_count", n_valid, 1024);
        chk("recap_lastpos", last_pos, 1023);
        chk("recap_a127", {18'd0, got_a[127]}, {18'd0, tc(-1)});
        chk("recap_a128", {18'd0, got_a[128]}, {18'd0, tc(0)});
        $display("step abort+recapture: pairs=%0d a127=%h a128=%h",
                 n_valid, got_a[127], got_a[128]);

        // ---- asynchronous reset mid-capture ----
        arm = 1'b1;
        tick();
        arm = 1'b0;
        repeat (3) tick();
        force_trig = 1'b1;
        tick();
        force_trig = 1'b0;
        repeat (20) tick();
        adc_otr_a = 1'b1;
        tick();
        adc_otr_a = 1'b0;
        tick();
        chk("rst_pre_ovr_a", {31'd0, ovr_a}, 32'd1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("arst_ovr", {30'd0, ovr_b, ovr_a}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        rd_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("arst_no_valid", {31'd0, rd_valid}, 32'd0);
        end
        rd_req = 1'b0;
        chk("arst_idle", {30'd0, done, busy}, 32'd0);
        $display("step reset: busy=%0d done=%0d rd_valid=%0d", busy, done, rd_valid);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
